// File: rtl/branch_seq_ctrl_pkg.sv
// Shared encodings for the branch sequencing controller.
// Interrupt states exist only when BRANCH_SEQ_CTRL_INT_EN is defined.
package branch_seq_ctrl_pkg;

  localparam int CNT_W = 2;

  typedef enum logic [2:0] {
    BR_NONE = 3'b000,
    BR_JZ   = 3'b001,
    BR_JN   = 3'b010,
    BR_JC   = 3'b011,
    BR_JV   = 3'b100,
    BR_LOOP = 3'b101,
    BR_JMP  = 3'b110,
    BR_RET  = 3'b111
  } btype_e;

  typedef enum logic [1:0] {
    PC_INC  = 2'b00,
    PC_TGT  = 2'b01,
    PC_LOAD = 2'b10,
    PC_HOLD = 2'b11
  } pc_sel_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FLUSH  = 3'd1,
    ST_POP    = 3'd2,
    ST_POP_LD = 3'd3
`ifdef BRANCH_SEQ_CTRL_INT_EN
    ,
    ST_PUSH   = 3'd4,
    ST_VEC    = 3'd5
`endif
  } state_e;

  // Taken branch that redirects straight to b_target (everything but NONE/RET).
  function automatic logic is_jump(input logic [2:0] bt);
    return (bt != BR_NONE) && (bt != BR_RET);
  endfunction

endpackage

// File: rtl/branch_flush_cnt.sv
// Loadable down-counter with zero flag; saturates at zero.
module branch_flush_cnt #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = load_val;
    else if (dec && (cnt_q != '0))
      cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt  = cnt_q;
  assign zero = (cnt_q == '0);

endmodule

// File: rtl/branch_seq_ctrl.sv
// PC-source / flush sequencer for taken branches, returns and (optionally)
// interrupt entry. Interrupt support is built only with BRANCH_SEQ_CTRL_INT_EN.
module branch_seq_ctrl
  import branch_seq_ctrl_pkg::*;
#(
  parameter int         FLUSH_CYC = 2,
  parameter logic [7:0] INT_VEC   = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] btype,
  input  logic       b_take,
  input  logic [7:0] b_target,
  input  logic [7:0] mem_rdata,
  input  logic       mem_ack,
  input  logic       intr_req,
  output logic [1:0] pc_sel,
  output logic [7:0] pc_load,
  output logic       flush,
  output logic       stk_rd,
  output logic       stk_wr,
  output logic       intr_ack,
  output logic       busy
);

  state_e     state_q, state_d;
  logic [7:0] pc_load_q, pc_load_d;
  pc_sel_e    pc_sel_c;
  logic       flush_c, stk_rd_c;
  logic       cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0] cnt;
`ifdef BRANCH_SEQ_CTRL_INT_EN
  logic       stk_wr_c, intr_ack_c;
`endif

  branch_flush_cnt #(.W(CNT_W)) u_flush_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (CNT_W'(FLUSH_CYC - 1)),
    .dec      (cnt_dec),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d   = state_q;
    pc_load_d = pc_load_q;
    pc_sel_c  = PC_INC;
    flush_c   = 1'b0;
    stk_rd_c  = 1'b0;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
`ifdef BRANCH_SEQ_CTRL_INT_EN
    stk_wr_c   = 1'b0;
    intr_ack_c = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (b_take && (btype == BR_RET)) begin
          pc_sel_c = PC_HOLD;
          flush_c  = 1'b1;
          state_d  = ST_POP;
        end else if (b_take && is_jump(btype)) begin
          pc_sel_c = PC_TGT;
          flush_c  = 1'b1;
          cnt_load = 1'b1;
          state_d  = ST_FLUSH;
        end
`ifdef BRANCH_SEQ_CTRL_INT_EN
        else if (intr_req && !b_take) begin
          pc_sel_c   = PC_HOLD;
          flush_c    = 1'b1;
          intr_ack_c = 1'b1;
          state_d    = ST_PUSH;
        end
`endif
      end
      // The redirect cycle in IDLE is the first flush cycle, so FLUSH
      // leaves once the count loaded with FLUSH_CYC-1 runs out.
      ST_FLUSH: begin
        flush_c = 1'b1;
        cnt_dec = 1'b1;
        if (cnt_zero || (cnt == CNT_W'(1)))
          state_d = ST_IDLE;
      end
      ST_POP: begin
        pc_sel_c = PC_HOLD;
        flush_c  = 1'b1;
        stk_rd_c = 1'b1;
        if (mem_ack) begin
          pc_load_d = mem_rdata;
          state_d   = ST_POP_LD;
        end
      end
      ST_POP_LD: begin
        pc_sel_c = PC_LOAD;
        flush_c  = 1'b1;
        state_d  = ST_IDLE;
      end
`ifdef BRANCH_SEQ_CTRL_INT_EN
      ST_PUSH: begin
        pc_sel_c = PC_HOLD;
        flush_c  = 1'b1;
        stk_wr_c = 1'b1;
        if (mem_ack) begin
          pc_load_d = INT_VEC;
          state_d   = ST_VEC;
        end
      end
      ST_VEC: begin
        pc_sel_c = PC_LOAD;
        flush_c  = 1'b1;
        state_d  = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pc_load_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      pc_load_q <= pc_load_d;
    end
  end

  assign pc_sel  = pc_sel_c;
  assign pc_load = pc_load_q;
  assign flush   = flush_c;
  assign stk_rd  = stk_rd_c;
  assign busy    = (state_q != ST_IDLE);

`ifdef BRANCH_SEQ_CTRL_INT_EN
  assign stk_wr   = stk_wr_c;
  assign intr_ack = intr_ack_c;
  // Target muxing lives in the PC datapath; only pc_sel is produced here.
  logic unused_in;
  assign unused_in = ^b_target;
`else
  assign stk_wr   = 1'b0;
  assign intr_ack = 1'b0;
  logic unused_in;
  assign unused_in = (^b_target) ^ intr_req ^ (|INT_VEC);
`endif

endmodule

// File: tb/tb_branch_seq_ctrl.sv
// Transaction-level bench: each operation expands to its expected per-cycle
// output trace; ignored inputs are randomised in non-IDLE cycles.
module tb_branch_seq_ctrl;

  localparam int         FLUSH_CYC = 2;
  localparam logic [7:0] INT_VEC   = 8'hC4;

  // {pc_sel[1:0], flush, stk_rd, stk_wr, intr_ack, busy}
  localparam logic [6:0] V_IDLE  = 7'b00_0_0_0_0_0;
  localparam logic [6:0] V_TAKE  = 7'b01_1_0_0_0_0;
  localparam logic [6:0] V_FLUSH = 7'b00_1_0_0_0_1;
  localparam logic [6:0] V_RET0  = 7'b11_1_0_0_0_0;
  localparam logic [6:0] V_POP   = 7'b11_1_1_0_0_1;
  localparam logic [6:0] V_LD    = 7'b10_1_0_0_0_1;
`ifdef BRANCH_SEQ_CTRL_INT_EN
  localparam logic [6:0] V_IACC  = 7'b11_1_0_0_1_0;
  localparam logic [6:0] V_PUSH  = 7'b11_1_0_1_0_1;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] btype;
  logic       b_take;
  logic [7:0] b_target;
  logic [7:0] mem_rdata;
  logic       mem_ack;
  logic       intr_req;
  logic [1:0] pc_sel;
  logic [7:0] pc_load;
  logic       flush, stk_rd, stk_wr, intr_ack, busy;

  int         n_assert = 0;
  int         n_fail   = 0;
  logic [7:0] exp_pc_load;

  branch_seq_ctrl #(.FLUSH_CYC(FLUSH_CYC), .INT_VEC(INT_VEC)) dut (
    .clk       (clk),
    .rst       (rst),
    .btype     (btype),
    .b_take    (b_take),
    .b_target  (b_target),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .intr_req  (intr_req),
    .pc_sel    (pc_sel),
    .pc_load   (pc_load),
    .flush     (flush),
    .stk_rd    (stk_rd),
    .stk_wr    (stk_wr),
    .intr_ack  (intr_ack),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic idle_in();
    b_take    = 1'b0;
    btype     = 3'($urandom);
    b_target  = 8'($urandom);
    mem_ack   = 1'b0;
    mem_rdata = 8'($urandom);
    intr_req  = 1'b0;
  endtask

  task automatic noise(input bit allow_ack);
    b_take    = 1'($urandom);
    btype     = 3'($urandom);
    b_target  = 8'($urandom);
    mem_rdata = 8'($urandom);
    intr_req  = 1'($urandom);
    mem_ack   = allow_ack ? 1'($urandom) : 1'b0;
  endtask

  // Called just after a falling edge with this cycle's inputs applied.
  task automatic tick(input string tag, input logic [6:0] exp_v);
    logic [6:0] obs;
    #1;
    obs = {pc_sel, flush, stk_rd, stk_wr, intr_ack, busy};
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s outputs: observed %b expected %b", tag, obs, exp_v);
    end
    n_assert++;
    assert (pc_load === exp_pc_load) else begin
      n_fail++;
      $error("FAIL %s pc_load: observed %h expected %h", tag, pc_load, exp_pc_load);
    end
    @(negedge clk);
  endtask

`ifdef BRANCH_SEQ_CTRL_INT_EN
  task automatic intr_seq(input int dly);
    tick("int_accept", V_IACC);
    for (int i = 1; i <= dly; i++) begin
      noise(1'b0);
      mem_ack = (i == dly);
      tick("int_push", V_PUSH);
    end
    exp_pc_load = INT_VEC;
    noise(1'b1);
    tick("int_vec", V_LD);
    idle_in();
    tick("int_idle", V_IDLE);
  endtask
`endif

  task automatic do_intr(input int dly);
    idle_in();
    intr_req = 1'b1;
`ifdef BRANCH_SEQ_CTRL_INT_EN
    intr_seq(dly);
`else
    if (dly > 0) tick("int_ignored", V_IDLE);
    idle_in();
    tick("int_idle", V_IDLE);
`endif
  endtask

  task automatic do_branch(input logic [2:0] bt, input logic [7:0] tgt, input bit with_intr);
    idle_in();
    b_take   = 1'b1;
    btype    = bt;
    b_target = tgt;
    intr_req = with_intr;
    tick("br_take", V_TAKE);
    for (int i = 1; i < FLUSH_CYC; i++) begin
      noise(1'b1);
      b_take = 1'b1;           // must neither restart nor redirect
      if (with_intr) intr_req = 1'b1;
      tick("br_flush", V_FLUSH);
    end
    if (with_intr) begin
      do_intr(1 + $urandom_range(0, 2));
    end else begin
      idle_in();
      tick("br_idle", V_IDLE);
    end
  endtask

  task automatic do_ret(input int dly, input logic [7:0] data);
    idle_in();
    b_take = 1'b1;
    btype  = 3'b111;
    tick("ret_take", V_RET0);
    for (int i = 1; i <= dly; i++) begin
      noise(1'b0);
      mem_ack = (i == dly);
      if (i == dly) mem_rdata = data;
      tick("ret_pop", V_POP);
    end
    exp_pc_load = data;
    noise(1'b1);
    tick("ret_load", V_LD);
    idle_in();
    tick("ret_idle", V_IDLE);
  endtask

  task automatic do_ret_reset(input int npop);
    idle_in();
    b_take = 1'b1;
    btype  = 3'b111;
    tick("rr_take", V_RET0);
    for (int i = 0; i < npop; i++) begin
      noise(1'b0);
      tick("rr_pop", V_POP);
    end
    noise(1'b0);
    rst = 1'b1;
    tick("rr_rst_cycle", V_POP);
    exp_pc_load = 8'h00;
    rst = 1'b0;
    idle_in();
    mem_ack   = 1'b1;
    mem_rdata = 8'hA5;
    tick("rr_late_ack", V_IDLE);
    idle_in();
    tick("rr_idle", V_IDLE);
  endtask

  task automatic do_none();
    idle_in();
    b_take = 1'b1;
    btype  = 3'b000;
    tick("none_take", V_IDLE);
    idle_in();
    tick("none_idle", V_IDLE);
  endtask

  initial begin
    rst         = 1'b1;
    exp_pc_load = 8'h00;
    idle_in();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    tick("reset", V_IDLE);

    do_ret_reset(2);
    do_branch(3'b110, 8'h3C, 1'b0);
    do_ret(3, 8'h5A);
    do_intr(1);
    do_branch(3'b001, 8'h10, 1'b1);
    do_none();
    do_ret(1, 8'hE7);

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 5))
        0: do_branch(3'($urandom_range(1, 6)), 8'($urandom), 1'b0);
        1: do_ret($urandom_range(1, 4), 8'($urandom));
        2: do_intr($urandom_range(1, 3));
        3: do_branch(3'($urandom_range(1, 6)), 8'($urandom), 1'b1);
        4: do_none();
        default: do_ret_reset($urandom_range(0, 3));
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_seq_ctrl.md
BRANCH_SEQ_CTRL -- requirements
Module: branch_seq_ctrl

Interface
REQ-001 Parameter: FLUSH_CYC, default 2, flush-hold cycles after a taken branch (legal 1..3).
REQ-002 Parameter: INT_VEC, default 8'h00, PC load value on interrupt entry.
REQ-003 Clock and reset: one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 btype  in  3  branch type from decode (000 NONE, 001 JZ, 010 JN, 011 JC, 100 JV, 101 LOOP, 110 JMP/CALL, 111 RET/RTI).
REQ-007 b_take  in  1  branch-taken decision from the branch unit, same cycle as btype.
REQ-008 b_target  in  8  taken-branch target address.
REQ-009 mem_rdata  in  8  stack read data (return address).
REQ-010 mem_ack  in  1  stack read/write complete, one-cycle pulse.
REQ-011 intr_req  in  1  level interrupt request.
REQ-012 pc_sel  out  2  PC source: 00 PC+1, 01 b_target, 10 pc_load, 11 hold.
REQ-013 pc_load  out  8  registered load value (return address or INT_VEC).
REQ-014 flush  out  1  squash IF/ID stage contents.
REQ-015 stk_rd / stk_wr  out  1 each  stack pop / push request, held until mem_ack.
REQ-016 intr_ack  out  1  one-cycle interrupt accept pulse.
REQ-017 busy  out  1  high in every state except IDLE.

Function
REQ-018 States: IDLE, FLUSH, POP, POP_LD, PUSH, VEC.
REQ-019 IDLE: pc_sel=00, flush=0, all requests low.
REQ-020 IDLE, b_take=1, btype!=111: pc_sel=01 same cycle (combinational), flush=1, next FLUSH with counter loaded FLUSH_CYC-1.
REQ-021 FLUSH: pc_sel=00, flush=1, counter decrements; at 0 return to IDLE; total flush cycles = FLUSH_CYC.
REQ-022 IDLE, b_take=1, btype=111: flush=1, pc_sel=11, next POP.
REQ-023 POP: stk_rd=1, pc_sel=11, flush=1; on mem_ack capture mem_rdata into pc_load, next POP_LD.
REQ-024 POP_LD: pc_sel=10 for exactly one cycle, flush=1, next IDLE.
REQ-025 b_take with btype=000 is ignored (IDLE, no flush).
REQ-026 b_take, btype and intr_req are sampled only in IDLE; ignored in all other states.
REQ-027 Simultaneous b_take and intr_req in IDLE: branch wins; interrupt is taken at the next IDLE cycle if still asserted.
REQ-028 mem_ack in a state with no request pending is ignored.
REQ-029 No timeout: POP/PUSH wait indefinitely for mem_ack.

Reset
REQ-030 rst=1 forces IDLE, counter 0, pc_load 8'h00, all outputs low (pc_sel=00) on the next edge, including mid-POP/PUSH; an in-flight mem_ack after reset is ignored.

Configuration
REQ-031 Macro BRANCH_SEQ_CTRL_INT_EN: when defined, IDLE with intr_req=1 and b_take=0 -> intr_ack pulse, flush=1, next PUSH (stk_wr=1, pc_sel=11 until mem_ack), then VEC (pc_load=INT_VEC, pc_sel=10 one cycle) -> IDLE.
REQ-032 Without BRANCH_SEQ_CTRL_INT_EN: intr_req ignored, intr_ack tied 0, stk_wr tied 0, PUSH/VEC states absent.

Structure
REQ-033 Shared CPU package holds BTYPE encodings (BR_NONE..BR_RET), PC_SEL encodings and the state enumeration.
REQ-034 One sub-module, branch_flush_cnt (loadable down-counter with zero flag), is natural; otherwise flat.

Verification
REQ-035 b_take=1, btype=110, b_target=8'h3C, FLUSH_CYC=2 -> pc_sel=01 that cycle, flush high 2 cycles, busy back low on the 3rd.
REQ-036 b_take=1, btype=111, mem_ack after 3 cycles with mem_rdata=8'h5A -> stk_rd high 3 cycles, then pc_sel=10 and pc_load=8'h5A for one cycle, IDLE.
REQ-037 INT_EN build, intr_req=1 idle, mem_ack after 1 cycle -> intr_ack one pulse, stk_wr one cycle, pc_sel=10 with pc_load=INT_VEC, IDLE.
REQ-038 b_take=1 (btype=001) and intr_req=1 same cycle -> branch flush sequence first, intr_ack on first IDLE cycle after.
REQ-039 rst asserted during POP before mem_ack; late mem_ack afterwards -> all outputs zero, state IDLE, pc_load unchanged at 8'h00.
REQ-040 b_take=1 with btype=000, and b_take=1 during FLUSH -> no flush, no state change / no restart of counter.
